imm_ext_stage: RTL and testbench

- Registered immediate-extraction and extension stage for the pipelined RV32/RV64 datapath.
- Takes a raw instruction word plus a format code. Produces the XLEN-wide immediate, sign- or zero-extended.
- Sits between decode and the ID/EX boundary, with valid/ready handshakes on both sides.
- Contains a 2-entry skid buffer so that in_ready is driven from a register only.

---
 rtl/imm_ext_stage_pkg.sv | 31 +++
 rtl/imm_ext_stage_if.sv | 30 +++
 rtl/imm_ext_stage_field_ext.sv | 68 ++++++
 rtl/imm_ext_stage.sv | 123 ++++++++++++
 tb/tb_imm_ext_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_stage_pkg.sv
// Shared definitions for the immediate extraction/extension stage:
// format codes, skid-buffer state encoding and the held-entry record.
package imm_ext_stage_pkg;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Entries are sized for the widest configuration; each instance uses the low bits.
    localparam int IMM_W_MAX = 64;
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        logic [TAG_W_MAX-1:0] tag;
        logic                 err;
    } entry_t;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return (fmt <= FMT_J);
    endfunction

endpackage

// File: rtl/imm_ext_stage_if.sv
// Upstream/downstream valid-ready bundle of the immediate stage.
// master = the side that drives in_* and out_ready, slave = the stage itself.
interface imm_ext_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [2:0]       in_fmt;
    logic             in_zext;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_inst, in_fmt, in_zext, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_inst, in_fmt, in_zext, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

endinterface

// File: rtl/imm_ext_stage_field_ext.sv
// Combinational RISC-V immediate field extraction with sign or zero fill to XLEN.
// Illegal format codes yield a zero immediate and raise o_err.
module imm_field_ext
    import imm_ext_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  logic [2:0]      i_fmt,
    input  logic            i_zext,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_field_ext: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [XLEN-1:0] ONES = '1;

    logic [XLEN-1:0] w_field;
    logic [XLEN-1:0] w_fill_mask;
    logic            w_fill_bit;
    logic            w_unused_opcode;

    // Every format keeps its most significant field bit in inst[31].
    assign w_fill_bit      = i_inst[31] & ~i_zext;
    assign w_unused_opcode = ^i_inst[6:0];

    always_comb begin
        w_field     = '0;
        w_fill_mask = '0;
        case (i_fmt)
            FMT_I: begin
                w_field     = XLEN'(i_inst[31:20]);
                w_fill_mask = ONES << 12;
            end
            FMT_S: begin
                w_field     = XLEN'({i_inst[31:25], i_inst[11:7]});
                w_fill_mask = ONES << 12;
            end
            FMT_B: begin
                w_field     = XLEN'({i_inst[31], i_inst[7], i_inst[30:25],
                                     i_inst[11:8], 1'b0});
                w_fill_mask = ONES << 13;
            end
            FMT_U: begin
                w_field     = XLEN'({i_inst[31:12], 12'b0});
                w_fill_mask = ONES << 32;
            end
            FMT_J: begin
                w_field     = XLEN'({i_inst[31], i_inst[19:12], i_inst[20],
                                     i_inst[30:21], 1'b0});
                w_fill_mask = ONES << 21;
            end
            default: begin
                w_field     = '0;
                w_fill_mask = '0;
            end
        endcase
    end

    assign o_imm = w_field | (w_fill_bit ? w_fill_mask : '0);
    assign o_err = ~fmt_legal(i_fmt);

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate stage with a 2-entry skid buffer; in_ready and out_*
// come straight from flops so neither handshake side sees a combinational path.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_EMPTY | nothing held; out_valid=0, in_ready=1
//   ST_ONE   | main entry presented; in_ready=1
//   ST_TWO   | main presented, skid holds the overflow; in_ready=0
module imm_ext_stage
    import imm_ext_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_ext_stage_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_ext_stage: XLEN must be 32 or 64");
        end
        if (TAG_W < 1 || TAG_W > TAG_W_MAX) begin : g_bad_tag_w
            $error("imm_ext_stage: TAG_W out of range");
        end
    endgenerate

    state_t          r_state;
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_in_ready;
    logic            r_out_valid;

    entry_t          w_new;
    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_accept;
    logic            w_xfer;
    logic            w_unused_main;

    imm_field_ext #(
        .XLEN (XLEN)
    ) u_field_ext (
        .i_inst (bus.in_inst),
        .i_fmt  (bus.in_fmt),
        .i_zext (bus.in_zext),
        .o_imm  (w_imm),
        .o_err  (w_err)
    );

    always_comb begin
        w_new     = '0;
        w_new.imm = IMM_W_MAX'(w_imm);
        w_new.tag = TAG_W_MAX'(bus.in_tag);
        w_new.err = w_err;
    end

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_xfer   = r_out_valid & bus.out_ready;

    // in_ready/out_valid are updated alongside r_state so they always reflect the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_new;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_xfer) begin
                        r_skid      <= w_new;
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_accept && w_xfer) begin
                        r_main      <= w_new;
                    end else if (w_xfer) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_xfer) begin
                        r_main      <= r_skid;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Upper entry bits beyond XLEN/TAG_W are carried but never presented.
    assign w_unused_main = ^{r_main.imm, r_main.tag};

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_imm   = r_main.imm[XLEN-1:0];
    assign bus.out_tag   = r_main.tag[TAG_W-1:0];
    assign bus.out_err   = r_main.err;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Drives identical traffic into XLEN=32 and XLEN=64 instances and checks both
// against a queue-based model of the 2-deep stage.
module tb_imm_ext_stage;

    logic clk;
    logic rst;
    logic flush;

    imm_ext_stage_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_ext_stage_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_ext_stage #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_ext_stage #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (b64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Sign extension done arithmetically: shift the field to the top of a longint and back.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] fmt,
                                            input logic z, input int xlen);
        logic [31:0] field;
        int          w;
        longint      s;
        logic [63:0] v;
        case (fmt)
            3'd0: begin field = {20'b0, inst[31:20]}; w = 12; end
            3'd1: begin field = {20'b0, inst[31:25], inst[11:7]}; w = 12; end
            3'd2: begin field = {19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; w = 13; end
            3'd3: begin field = {inst[31:12], 12'b0}; w = 32; end
            3'd4: begin field = {11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; w = 21; end
            default: return 64'd0;
        endcase
        if (z) begin
            v = {32'b0, field};
        end else begin
            s = longint'({32'b0, field});
            s = s <<< (64 - w);
            s = s >>> (64 - w);
            v = s;
        end
        if (xlen == 32) v[63:32] = 32'd0;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] fmt,
                         input logic z, input logic [4:0] tag, input logic ordy, input logic fl);
        b32.in_valid = v;  b64.in_valid = v;
        b32.in_inst = inst; b64.in_inst = inst;
        b32.in_fmt = fmt;  b64.in_fmt = fmt;
        b32.in_zext = z;   b64.in_zext = z;
        b32.in_tag = tag;  b64.in_tag = tag;
        b32.out_ready = ordy; b64.out_ready = ordy;
        flush = fl;
    endtask

    // Advance the model by one clock edge using the inputs currently driven, then wait for negedge.
    task automatic cycle();
        exp_t        e;
        logic [63:0] t;
        bit          acc;
        bit          xfer;
        acc  = b32.in_valid && (q.size() < 2);
        xfer = (q.size() > 0) && b32.out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) begin
                t     = ref_imm(b32.in_inst, b32.in_fmt, b32.in_zext, 32);
                e.i32 = t[31:0];
                e.i64 = ref_imm(b32.in_inst, b32.in_fmt, b32.in_zext, 64);
                e.tag = b32.in_tag;
                e.err = (b32.in_fmt > 3'd4);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'd0, 3'd0, 0, 5'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        vectors += 10;
        if (b32.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid32 got %b want 0", b32.out_valid); end
        if (b64.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid64 got %b want 0", b64.out_valid); end
        if (b32.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready32 got %b want 1", b32.in_ready); end
        if (b64.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready64 got %b want 1", b64.in_ready); end
        if (b32.out_imm !== 32'd0) begin miscompares++; $display("FAIL reset_imm32 got %h want 0", b32.out_imm); end
        if (b64.out_imm !== 64'd0) begin miscompares++; $display("FAIL reset_imm64 got %h want 0", b64.out_imm); end
        if (b32.out_tag !== 5'd0) begin miscompares++; $display("FAIL reset_tag32 got %h want 0", b32.out_tag); end
        if (b64.out_tag !== 5'd0) begin miscompares++; $display("FAIL reset_tag64 got %h want 0", b64.out_tag); end
        if (b32.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_err32 got %b want 0", b32.out_err); end
        if (b64.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_err64 got %b want 0", b64.out_err); end
        rst = 1'b0;
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] inst_t [8] = '{32'hFFF00093, 32'h80000037, 32'h80000037, 32'h80000093,
                                    32'hFE000EE3, 32'h0080006F, 32'hFE112E23, 32'hFFFFFFFF};
        logic [2:0]  fmt_t  [8] = '{3'd0, 3'd3, 3'd3, 3'd0, 3'd2, 3'd4, 3'd1, 3'd6};
        logic        z_t    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] e32_t  [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000800,
                                    32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC, 32'h00000000};
        logic [63:0] e64_t  [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_80000000,
                                    64'h00000000_80000000, 64'h00000000_00000800,
                                    64'hFFFFFFFF_FFFFFFFC, 64'h00000000_00000008,
                                    64'hFFFFFFFF_FFFFFFFC, 64'h00000000_00000000};
        logic        err_t  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1, inst_t[i], fmt_t[i], z_t[i], 5'(i + 1), 1, 0);
            cycle();
            drive(0, 32'd0, 3'd0, 0, 5'd0, 1, 0);
            vectors += 5;
            if (b32.out_valid !== 1'b1 || b64.out_valid !== 1'b1) begin
                miscompares++; $display("FAIL dir%0d_valid got %b/%b want 1/1", i, b32.out_valid, b64.out_valid);
            end
            if (b32.out_imm !== e32_t[i]) begin miscompares++; $display("FAIL dir%0d_imm32 got %h want %h", i, b32.out_imm, e32_t[i]); end
            if (b64.out_imm !== e64_t[i]) begin miscompares++; $display("FAIL dir%0d_imm64 got %h want %h", i, b64.out_imm, e64_t[i]); end
            if (b32.out_err !== err_t[i] || b64.out_err !== err_t[i]) begin
                miscompares++; $display("FAIL dir%0d_err got %b/%b want %b", i, b32.out_err, b64.out_err, err_t[i]);
            end
            if (b32.out_tag !== 5'(i + 1)) begin miscompares++; $display("FAIL dir%0d_tag got %0d want %0d", i, b32.out_tag, i + 1); end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        int   next_tag = 1;
        int   got[$];
        logic ordy;
        logic v;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ordy = (cyc >= 3);
            if (cyc == 2) begin
                vectors += 2;
                if (b32.in_ready !== 1'b0 || b64.in_ready !== 1'b0) begin
                    miscompares++; $display("FAIL bp_ready_drop got %b/%b want 0/0", b32.in_ready, b64.in_ready);
                end
                if (b32.out_tag !== 5'd1 || b64.out_tag !== 5'd1) begin
                    miscompares++; $display("FAIL bp_tag_hold got %0d/%0d want 1", b32.out_tag, b64.out_tag);
                end
            end
            if (b32.out_valid && ordy) begin
                got.push_back(int'(b32.out_tag));
                vectors++;
                if (b64.out_tag !== b32.out_tag || b64.out_valid !== 1'b1) begin
                    miscompares++; $display("FAIL bp_tag64 got %0d want %0d", b64.out_tag, b32.out_tag);
                end
            end
            v = (next_tag <= 4);
            drive(v, $urandom, 3'($urandom_range(4, 0)), 1'($urandom), 5'(next_tag), ordy, 0);
            if (v && b32.in_ready) next_tag++;
            cycle();
        end
        vectors++;
        if (got.size() != 4) begin
            miscompares++; $display("FAIL bp_count got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[i] != i + 1) begin miscompares++; $display("FAIL bp_order[%0d] got %0d want %0d", i, got[i], i + 1); end
            end
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h00500093, 3'd0, 0, 5'd5, 0, 0); cycle();
        drive(1, 32'h00600093, 3'd0, 0, 5'd6, 0, 0); cycle();
        vectors++;
        if (b32.in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_two_ready got %b want 0", b32.in_ready); end
        drive(1, 32'h00700093, 3'd0, 0, 5'd7, 0, 1); cycle();
        vectors += 2;
        if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL fl_two_valid got %b/%b want 0/0", b32.out_valid, b64.out_valid);
        end
        if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL fl_two_ready1 got %b/%b want 1/1", b32.in_ready, b64.in_ready);
        end
        drive(1, 32'h00800093, 3'd0, 0, 5'd8, 0, 0); cycle();
        drive(1, 32'h00900093, 3'd0, 0, 5'd9, 1, 1); cycle();
        vectors += 2;
        if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL fl_one_valid got %b/%b want 0/0", b32.out_valid, b64.out_valid);
        end
        if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL fl_one_ready got %b/%b want 1/1", b32.in_ready, b64.in_ready);
        end
        drive(0, 32'd0, 3'd0, 0, 5'd0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
                miscompares++; $display("FAIL fl_ghost%0d got valid %b/%b tag %0d want 0", i, b32.out_valid, b64.out_valid, b32.out_tag);
            end
        end
    endtask

    task automatic test_random();
        logic ev;
        logic er;
        for (int n = 0; n < 400; n++) begin
            ev = (q.size() > 0);
            er = (q.size() < 2);
            vectors += 4;
            if (b32.out_valid !== ev) begin miscompares++; $display("FAIL rnd%0d_valid32 got %b want %b", n, b32.out_valid, ev); end
            if (b64.out_valid !== ev) begin miscompares++; $display("FAIL rnd%0d_valid64 got %b want %b", n, b64.out_valid, ev); end
            if (b32.in_ready !== er) begin miscompares++; $display("FAIL rnd%0d_ready32 got %b want %b", n, b32.in_ready, er); end
            if (b64.in_ready !== er) begin miscompares++; $display("FAIL rnd%0d_ready64 got %b want %b", n, b64.in_ready, er); end
            if (ev) begin
                vectors += 4;
                if (b32.out_imm !== q[0].i32) begin miscompares++; $display("FAIL rnd%0d_imm32 got %h want %h", n, b32.out_imm, q[0].i32); end
                if (b64.out_imm !== q[0].i64) begin miscompares++; $display("FAIL rnd%0d_imm64 got %h want %h", n, b64.out_imm, q[0].i64); end
                if (b32.out_tag !== q[0].tag || b64.out_tag !== q[0].tag) begin
                    miscompares++; $display("FAIL rnd%0d_tag got %0d/%0d want %0d", n, b32.out_tag, b64.out_tag, q[0].tag);
                end
                if (b32.out_err !== q[0].err || b64.out_err !== q[0].err) begin
                    miscompares++; $display("FAIL rnd%0d_err got %b/%b want %b", n, b32.out_err, b64.out_err, q[0].err);
                end
            end
            drive(1'($urandom_range(99, 0) < 70), $urandom, 3'($urandom_range(7, 0)), 1'($urandom),
                  5'($urandom), 1'($urandom_range(99, 0) < 60), 1'($urandom_range(99, 0) < 4));
            cycle();
        end
        drive(0, 32'd0, 3'd0, 0, 5'd0, 1, 0);
        cycle(); cycle();
    endtask

    task automatic test_async_reset();
        drive(1, 32'hFFF00093, 3'd0, 0, 5'd3, 0, 0); cycle();
        drive(1, 32'h80000037, 3'd3, 0, 5'd4, 0, 0); cycle();
        drive(0, 32'd0, 3'd0, 0, 5'd0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors += 3;
        if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL arst_valid got %b/%b want 0/0", b32.out_valid, b64.out_valid);
        end
        if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL arst_ready got %b/%b want 1/1", b32.in_ready, b64.in_ready);
        end
        if (b64.out_imm !== 64'd0 || b32.out_tag !== 5'd0) begin
            miscompares++; $display("FAIL arst_clear got imm %h tag %0d want 0/0", b64.out_imm, b32.out_tag);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h0080006F, 3'd4, 0, 5'd9, 1, 0); cycle();
        drive(0, 32'd0, 3'd0, 0, 5'd0, 1, 0);
        vectors++;
        if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h8 || b32.out_tag !== 5'd9) begin
            miscompares++; $display("FAIL arst_recover got v%b imm %h tag %0d want v1 imm 8 tag 9", b32.out_valid, b32.out_imm, b32.out_tag);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
